mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (loads/stores).
- One transaction is outstanding at a time. The block arbitrates, sequences the memory handshake and drives per-requester stall signals, which the hazard unit ORs into stallf/stalld and stallm/stallw.
- Data has priority, with a bounded-burst guard so fetch is never starved.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the unified memory port shared by fetch and memory stages.
// Optional response timeout is compiled in with `define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] irdata,
    output logic          istall,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic [DW-1:0] drdata,
    output logic          dstall,
    output logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [2:0] BURST_MAX = 3'(MAX_DATA_BURST);

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [2:0]    burst_r;
    logic          mem_valid_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic [DW-1:0] irdata_r;
    logic [DW-1:0] drdata_r;
    logic          grant_d_s;
    logic          grant_i_s;
    logic          busy_s;
    logic          timeout_s;
    logic          done_i_s;
    logic          done_d_s;
    logic [DW-1:0] rdata_s;

    // Data wins unless fetch is waiting and the data burst budget is spent.
    assign grant_d_s = (state_r == IDLE) && dreq && (!ireq || (burst_r < BURST_MAX));
    assign grant_i_s = (state_r == IDLE) && !grant_d_s && ireq;
    assign busy_s    = (state_r == BUSY_I) || (state_r == BUSY_D);
    assign done_i_s  = (state_r == BUSY_I) && (mem_ready || timeout_s);
    assign done_d_s  = (state_r == BUSY_D) && (mem_ready || timeout_s);
    assign rdata_s   = timeout_s ? {DW{1'b0}} : mem_rdata;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] timer_r;
    logic       err_r;

    assign timeout_s = busy_s && !mem_ready && (timer_r == TIMEOUT_LAST);
    assign err       = err_r;

    // Wait-cycle timer and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r <= 8'd0;
            err_r   <= 1'b0;
        end else begin
            if (grant_d_s || grant_i_s) begin
                timer_r <= 8'd0;
            end else if (busy_s && !mem_ready && !timeout_s) begin
                timer_r <= timer_r + 8'd1;
            end else begin
                timer_r <= timer_r;
            end
            err_r <= err_r | timeout_s;
        end
    end
`else
    localparam int timeout_unused = TIMEOUT;
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s = BUSY_D;
                end else if (grant_i_s) begin
                    state_nxt_s = BUSY_I;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY_I: begin
                if (done_i_s) state_nxt_s = IDLE;
                else          state_nxt_s = BUSY_I;
            end
            BUSY_D: begin
                if (done_d_s) state_nxt_s = IDLE;
                else          state_nxt_s = BUSY_D;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, memory-side request registers, burst counter and read-data copies.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            burst_r     <= 3'd0;
            mem_valid_r <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            irdata_r    <= {DW{1'b0}};
            drdata_r    <= {DW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (grant_d_s) begin
                mem_valid_r <= 1'b1;
                mem_we_r    <= dwe;
                mem_addr_r  <= daddr;
                mem_wdata_r <= dwdata;
                if (ireq && (burst_r < BURST_MAX)) burst_r <= burst_r + 3'd1;
                else if (ireq)                     burst_r <= burst_r;
                else                               burst_r <= 3'd0;
            end else if (grant_i_s) begin
                mem_valid_r <= 1'b1;
                mem_we_r    <= 1'b0;
                mem_addr_r  <= iaddr;
                burst_r     <= 3'd0;
            end else if (done_i_s || done_d_s) begin
                mem_valid_r <= 1'b0;
            end else begin
                mem_valid_r <= mem_valid_r;
            end
            if (done_i_s)                  irdata_r <= rdata_s;
            if (done_d_s && !mem_we_r)     drdata_r <= rdata_s;
        end
    end

    assign mem_valid = mem_valid_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign istall    = ireq & ~done_i_s;
    assign dstall    = dreq & ~done_d_s;
    assign irdata    = done_i_s ? rdata_s : irdata_r;
    assign drdata    = (done_d_s && !mem_we_r) ? rdata_s : drdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction table with a scoreboard,
// plus hand-written contention, async-reset and (optional) timeout sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq, dreq, dwe, mem_ready;
    logic [31:0] iaddr, daddr, dwdata, mem_rdata;
    logic [31:0] irdata, drdata, mem_addr, mem_wdata;
    logic        istall, dstall, mem_valid, mem_we, err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] exp_rd;
    } txn_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } sb_t;

    sb_t  sb_q[$];
    txn_t vec[8];

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .istall(istall),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .drdata(drdata), .dstall(dstall),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic run_txn(input txn_t t);
        sb_t         e;
        logic        done = 1'b0;
        logic [31:0] rd   = 32'h0;
        @(negedge clk);
        ireq = !t.data; dreq = t.data; dwe = t.we;
        iaddr = t.addr; daddr = t.addr; dwdata = t.wdata;
        mem_ready = 1'b0; mem_rdata = 32'h0BAD_0BAD;
        e.addr = t.addr; e.we = t.data & t.we; e.wdata = t.wdata;
        sb_q.push_back(e);
        #1;
        chk("req_stall", t.data ? dstall : istall, 32'd1);
        chk("req_idle_valid", mem_valid, 32'd0);
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (n >= t.waits) begin
                mem_ready = 1'b1;
                mem_rdata = t.rdata;
            end
            #1;
            chk("busy_valid", mem_valid, 32'd1);
            chk("busy_we", mem_we, 32'(t.data & t.we));
            chk("busy_addr", mem_addr, t.addr);
            if (t.data && t.we) chk("busy_wdata", mem_wdata, t.wdata);
            if (mem_ready) begin
                e = sb_q.pop_front();
                chk("sb_addr", mem_addr, e.addr);
                chk("sb_we", mem_we, 32'(e.we));
                if (e.we) chk("sb_wdata", mem_wdata, e.wdata);
                chk("done_stall", t.data ? dstall : istall, 32'd0);
                rd = t.data ? drdata : irdata;
                chk("done_rdata", rd, t.exp_rd);
                done = 1'b1;
            end else begin
                chk("wait_stall", t.data ? dstall : istall, 32'd1);
            end
        end
        @(negedge clk);
        ireq = 1'b0; dreq = 1'b0; mem_ready = 1'b0; mem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("post_valid", mem_valid, 32'd0);
        rd = t.data ? drdata : irdata;
        chk("post_rdata", rd, t.exp_rd);
`ifndef ARB_TIMEOUT_EN
        chk("err_zero", err, 32'd0);
`endif
    endtask

    initial begin
        int grants;
        logic [31:0] exp_addr;

        //           data we   addr           wdata          waits rdata          exp_rd
        vec[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vec[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_0055, 2, 32'h0BAD_F00D, 32'h0000_0000};
        vec[2] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         1, 32'h1234_5678, 32'h1234_5678};
        vec[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         3, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vec[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 32'h1111_1111, 32'h1234_5678};
        vec[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         0, 32'h0000_0000, 32'h0000_0000};
        vec[6] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vec[7] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         4, 32'hA5A5_5A5A, 32'hA5A5_5A5A};

        reset = 1'b0; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; mem_ready = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dwdata = 32'h0; mem_rdata = 32'h0;
        #1;
        chk("rst_valid", mem_valid, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_irdata", irdata, 32'd0);
        chk("rst_err", err, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(vec[i]);

        // Contention: both requesters held, zero-wait memory.
        @(negedge clk);
        ireq = 1'b1; dreq = 1'b1; dwe = 1'b0;
        iaddr = 32'h0000_1000; daddr = 32'h0000_2000;
        mem_ready = 1'b1; mem_rdata = 32'h0;
        grants = 0;
        for (int c = 0; c < 60 && grants < 10; c++) begin
            #1;
            if (mem_valid) begin
                exp_addr = (grants % 5 == 4) ? 32'h0000_1000 : 32'h0000_2000;
                chk("cont_order", mem_addr, exp_addr);
                chk("cont_istall", istall, 32'((grants % 5) != 4));
                chk("cont_dstall", dstall, 32'((grants % 5) == 4));
                grants++;
            end else begin
                chk("cont_idle_istall", istall, 32'd1);
                chk("cont_idle_dstall", dstall, 32'd1);
            end
            @(negedge clk);
        end
        chk("cont_grants", 32'(grants), 32'd10);
        ireq = 1'b0; dreq = 1'b0; mem_ready = 1'b0;

        // Async reset in the middle of a stalled store.
        @(negedge clk);
        dreq = 1'b1; dwe = 1'b1; daddr = 32'h0000_0040; dwdata = 32'h0000_0055;
        @(negedge clk);
        #1;
        chk("ar_busy", mem_valid, 32'd1);
        #1;
        reset = 1'b0; dreq = 1'b0;
        #1;
        chk("ar_valid", mem_valid, 32'd0);
        chk("ar_we", mem_we, 32'd0);
        chk("ar_addr", mem_addr, 32'd0);
        chk("ar_wdata", mem_wdata, 32'd0);
        chk("ar_irdata", irdata, 32'd0);
        chk("ar_drdata", drdata, 32'd0);
        @(negedge clk);
        reset = 1'b1; ireq = 1'b1; iaddr = 32'h0000_0300;
        mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
        #1;
        chk("ar_req_istall", istall, 32'd1);
        @(negedge clk);
        #1;
        chk("ar_grant_valid", mem_valid, 32'd1);
        chk("ar_grant_addr", mem_addr, 32'h0000_0300);
        chk("ar_grant_istall", istall, 32'd0);
        chk("ar_grant_irdata", irdata, 32'h0000_0077);
        @(negedge clk);
        ireq = 1'b0; mem_ready = 1'b0;

`ifdef ARB_TIMEOUT_EN
        run_txn(vec[2]);
        @(negedge clk);
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h0000_0500;
        mem_ready = 1'b0; mem_rdata = 32'h1234_ABCD;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            #1;
            if (c < 15) begin
                chk("to_wait_dstall", dstall, 32'd1);
            end else begin
                chk("to_dstall", dstall, 32'd0);
                chk("to_drdata", drdata, 32'd0);
            end
        end
        @(negedge clk);
        dreq = 1'b0;
        #1;
        chk("to_idle", mem_valid, 32'd0);
        chk("to_err", err, 32'd1);
        run_txn(vec[0]);
        chk("to_err_sticky", err, 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
